// File: rtl/mpt_tlb.sv
// SDID-tagged permission cache sitting between the MPT walker and the address checker.
// Registered lookup response, refill allocation with round-robin eviction, swept flush.
module mpt_tlb #(
  parameter int NUM_ENTRIES = 16,
  parameter int PLEN        = 56,
  parameter int SDID_LEN    = 6
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                lookup_valid_i,
  output logic                lookup_ready_o,
  input  logic [PLEN-1:0]     lookup_paddr_i,
  input  logic [SDID_LEN-1:0] lookup_sdid_i,
  input  logic [1:0]          lookup_access_i,
  output logic                resp_valid_o,
  output logic                resp_hit_o,
  output logic [1:0]          resp_perm_o,
  output logic                resp_allow_o,
  input  logic                refill_valid_i,
  output logic                refill_ready_o,
  input  logic [PLEN-1:0]     refill_paddr_i,
  input  logic [SDID_LEN-1:0] refill_sdid_i,
  input  logic [1:0]          refill_size_i,
  input  logic [1:0]          refill_perm_i,
  input  logic                flush_i,
  input  logic                flush_sdid_valid_i,
  input  logic [SDID_LEN-1:0] flush_sdid_i,
  output logic                busy_o,
  output logic                flush_done_o
);
  localparam int PPN_W = PLEN - 12;
  localparam int IDX_W = $clog2(NUM_ENTRIES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);

  typedef enum logic {S_IDLE = 1'b0, S_FLUSH = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [IDX_W-1:0]      rr_q, rr_d;
  logic                  fl_sdid_valid_q, fl_sdid_valid_d;
  logic [SDID_LEN-1:0]   fl_sdid_q, fl_sdid_d;
  logic                  flush_done_q, flush_done_d;

  logic [NUM_ENTRIES-1:0] valid_q;
  logic [SDID_LEN-1:0]    sdid_q [NUM_ENTRIES];
  logic [PPN_W-1:0]       ppn_q  [NUM_ENTRIES];
  logic [1:0]             size_q [NUM_ENTRIES];
  logic [1:0]             perm_q [NUM_ENTRIES];

  logic                  resp_valid_q, resp_hit_q, resp_allow_q;
  logic [1:0]            resp_perm_q;

  logic                  lk_hit, lk_allow;
  logic [1:0]            lk_perm;
  logic                  same_hit, free_hit;
  logic [IDX_W-1:0]      same_idx, free_idx, wr_idx;
  logic                  lookup_fire, refill_wr, clr_en;
  logic [PPN_W-1:0]      lookup_ppn, refill_ppn;
  logic                  unused_paddr_bits;

  // Clears the ppn bits that fall inside a 2M or 1G page.
  function automatic logic [PPN_W-1:0] size_mask(input logic [1:0] size);
    logic [PPN_W-1:0] m;
    m = '1;
    if (size == 2'b01)      m[8:0]  = '0;
    else if (size == 2'b10) m[17:0] = '0;
    return m;
  endfunction

  assign lookup_ppn        = lookup_paddr_i[PLEN-1:12];
  assign refill_ppn        = refill_paddr_i[PLEN-1:12] & size_mask(refill_size_i);
  assign unused_paddr_bits = ^{lookup_paddr_i[11:0], refill_paddr_i[11:0]};

  // Descending scans so the lowest matching index is the one left standing.
  always_comb begin
    lk_hit   = 1'b0;
    lk_perm  = 2'b00;
    same_hit = 1'b0;
    same_idx = '0;
    free_hit = 1'b0;
    free_idx = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (valid_q[i] && sdid_q[i] == lookup_sdid_i &&
          (lookup_ppn & size_mask(size_q[i])) == ppn_q[i]) begin
        lk_hit  = 1'b1;
        lk_perm = perm_q[i];
      end
      if (valid_q[i] && sdid_q[i] == refill_sdid_i &&
          size_q[i] == refill_size_i && ppn_q[i] == refill_ppn) begin
        same_hit = 1'b1;
        same_idx = IDX_W'(i);
      end
      if (!valid_q[i]) begin
        free_hit = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    lk_allow = 1'b0;
    case (lookup_access_i)
      2'b01:   lk_allow = lk_hit && (lk_perm != 2'b00);
      2'b10:   lk_allow = lk_hit && lk_perm[1];
      2'b11:   lk_allow = lk_hit && lk_perm[0];
      default: lk_allow = 1'b0;
    endcase
  end

  always_comb begin
    state_d         = state_q;
    idx_d           = idx_q;
    fl_sdid_valid_d = fl_sdid_valid_q;
    fl_sdid_d       = fl_sdid_q;
    flush_done_d    = 1'b0;
    lookup_ready_o  = 1'b0;
    refill_ready_o  = 1'b0;
    busy_o          = 1'b0;
    clr_en          = 1'b0;
    case (state_q)
      S_IDLE: begin
        lookup_ready_o = !flush_i;
        refill_ready_o = !flush_i;
        if (flush_i) begin
          state_d         = S_FLUSH;
          fl_sdid_valid_d = flush_sdid_valid_i;
          fl_sdid_d       = flush_sdid_i;
          idx_d           = '0;
        end
      end
      S_FLUSH: begin
        busy_o = 1'b1;
        clr_en = !fl_sdid_valid_q || (sdid_q[idx_q] == fl_sdid_q);
        idx_d  = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d      = S_IDLE;
          flush_done_d = 1'b1;
          idx_d        = '0;
        end
      end
    endcase
  end

  assign lookup_fire = lookup_valid_i && lookup_ready_o;
  assign refill_wr   = refill_valid_i && refill_ready_o && (refill_size_i != 2'b11);
  assign wr_idx      = same_hit ? same_idx : (free_hit ? free_idx : rr_q);
  assign rr_d        = (refill_wr && !same_hit && !free_hit) ? rr_q + 1'b1 : rr_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q         <= S_IDLE;
      idx_q           <= '0;
      rr_q            <= '0;
      fl_sdid_valid_q <= 1'b0;
      fl_sdid_q       <= '0;
      flush_done_q    <= 1'b0;
      valid_q         <= '0;
      resp_valid_q    <= 1'b0;
      resp_hit_q      <= 1'b0;
      resp_perm_q     <= 2'b00;
      resp_allow_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      idx_q           <= idx_d;
      rr_q            <= rr_d;
      fl_sdid_valid_q <= fl_sdid_valid_d;
      fl_sdid_q       <= fl_sdid_d;
      flush_done_q    <= flush_done_d;
      resp_valid_q    <= lookup_fire;
      resp_hit_q      <= lookup_fire && lk_hit;
      resp_perm_q     <= lookup_fire ? lk_perm : 2'b00;
      resp_allow_q    <= lookup_fire && lk_allow;
      if (refill_wr) valid_q[wr_idx] <= 1'b1;
      if (clr_en)    valid_q[idx_q]  <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (refill_wr) begin
      sdid_q[wr_idx] <= refill_sdid_i;
      ppn_q[wr_idx]  <= refill_ppn;
      size_q[wr_idx] <= refill_size_i;
      perm_q[wr_idx] <= refill_perm_i;
    end
  end

  assign resp_valid_o = resp_valid_q;
  assign resp_hit_o   = resp_hit_q;
  assign resp_perm_o  = resp_perm_q;
  assign resp_allow_o = resp_allow_q;
  assign flush_done_o = flush_done_q;

endmodule

// File: tb/tb_mpt_tlb.sv
// Bench for mpt_tlb: directed vectors, hand-written flush/eviction/reset sequences and
// randomized traffic, all checked against a page-level reference model.
module tb_mpt_tlb;
  localparam int NE = 4;
  localparam int PL = 56;
  localparam int SL = 6;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          lookup_valid_i, lookup_ready_o;
  logic [PL-1:0] lookup_paddr_i;
  logic [SL-1:0] lookup_sdid_i;
  logic [1:0]    lookup_access_i;
  logic          resp_valid_o, resp_hit_o, resp_allow_o;
  logic [1:0]    resp_perm_o;
  logic          refill_valid_i, refill_ready_o;
  logic [PL-1:0] refill_paddr_i;
  logic [SL-1:0] refill_sdid_i;
  logic [1:0]    refill_size_i, refill_perm_i;
  logic          flush_i, flush_sdid_valid_i;
  logic [SL-1:0] flush_sdid_i;
  logic          busy_o, flush_done_o;

  mpt_tlb #(.NUM_ENTRIES(NE), .PLEN(PL), .SDID_LEN(SL)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .lookup_valid_i(lookup_valid_i), .lookup_ready_o(lookup_ready_o),
    .lookup_paddr_i(lookup_paddr_i), .lookup_sdid_i(lookup_sdid_i),
    .lookup_access_i(lookup_access_i),
    .resp_valid_o(resp_valid_o), .resp_hit_o(resp_hit_o),
    .resp_perm_o(resp_perm_o), .resp_allow_o(resp_allow_o),
    .refill_valid_i(refill_valid_i), .refill_ready_o(refill_ready_o),
    .refill_paddr_i(refill_paddr_i), .refill_sdid_i(refill_sdid_i),
    .refill_size_i(refill_size_i), .refill_perm_i(refill_perm_i),
    .flush_i(flush_i), .flush_sdid_valid_i(flush_sdid_valid_i),
    .flush_sdid_i(flush_sdid_i),
    .busy_o(busy_o), .flush_done_o(flush_done_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: pages held as aligned base addresses.
  typedef struct {
    bit              v;
    int unsigned     sd;
    longint unsigned base;
    int              sz;
    int              pm;
  } ment_t;

  ment_t m[NE];
  int    m_rr;
  int    m_left;

  typedef struct {
    bit          lv;
    logic [55:0] lpa;
    logic [5:0]  lsd;
    logic [1:0]  lacc;
    bit          rv;
    logic [55:0] rpa;
    logic [5:0]  rsd;
    logic [1:0]  rsz;
    logic [1:0]  rpm;
    bit          chk;
    bit          eh;
    logic [1:0]  ep;
    bit          ea;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkv(bit lv, logic [55:0] lpa, logic [5:0] lsd, logic [1:0] lacc,
                               bit rv, logic [55:0] rpa, logic [5:0] rsd, logic [1:0] rsz,
                               logic [1:0] rpm, bit chk, bit eh, logic [1:0] ep, bit ea);
    vec_t v;
    v.lv = lv; v.lpa = lpa; v.lsd = lsd; v.lacc = lacc;
    v.rv = rv; v.rpa = rpa; v.rsd = rsd; v.rsz = rsz; v.rpm = rpm;
    v.chk = chk; v.eh = eh; v.ep = ep; v.ea = ea;
    return v;
  endfunction

  function automatic int shamt(int sz);
    return (sz == 0) ? 12 : (sz == 1) ? 21 : 30;
  endfunction

  task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NE; i++) m[i].v = 0;
    m_rr   = 0;
    m_left = 0;
  endtask

  task automatic clr_in();
    lookup_valid_i = 0; lookup_paddr_i = '0; lookup_sdid_i = '0; lookup_access_i = 2'b00;
    refill_valid_i = 0; refill_paddr_i = '0; refill_sdid_i = '0;
    refill_size_i = 2'b00; refill_perm_i = 2'b00;
    flush_i = 0; flush_sdid_valid_i = 0; flush_sdid_i = '0;
  endtask

  // One clock: check readies, advance the model, then check registered outputs.
  task automatic tick();
    bit idle, lfire, rfire, ffire;
    bit e_rv, e_hit, e_allow, e_busy, e_done, r, w, x;
    int e_perm, sh, tgt;
    longint unsigned pa, base;
    #2;
    idle = (m_left == 0);
    if (!rst_i) begin
      chk("lookup_ready", lookup_ready_o, idle && !flush_i);
      chk("refill_ready", refill_ready_o, idle && !flush_i);
    end
    e_rv = 0; e_hit = 0; e_perm = 0; e_allow = 0;
    if (rst_i) begin
      model_reset();
      e_busy = 0;
      e_done = 0;
    end else begin
      lfire = idle && !flush_i && lookup_valid_i;
      rfire = idle && !flush_i && refill_valid_i;
      ffire = idle && flush_i;
      if (lfire) begin
        e_rv = 1;
        pa = 64'(lookup_paddr_i);
        for (int i = 0; i < NE; i++) begin
          sh = shamt(m[i].sz);
          if (!e_hit && m[i].v && m[i].sd == int'(lookup_sdid_i) &&
              (pa >> sh) == (m[i].base >> sh)) begin
            e_hit  = 1;
            e_perm = m[i].pm;
          end
        end
        r = (e_perm != 0);
        w = (e_perm == 2 || e_perm == 3);
        x = (e_perm == 1 || e_perm == 3);
        case (int'(lookup_access_i))
          1:       e_allow = e_hit && r;
          2:       e_allow = e_hit && w;
          3:       e_allow = e_hit && x;
          default: e_allow = 0;
        endcase
      end
      if (rfire && refill_size_i != 2'b11) begin
        sh   = shamt(int'(refill_size_i));
        base = (64'(refill_paddr_i) >> sh) << sh;
        tgt  = -1;
        for (int i = 0; i < NE; i++)
          if (tgt < 0 && m[i].v && m[i].sd == int'(refill_sdid_i) &&
              m[i].sz == int'(refill_size_i) && m[i].base == base) tgt = i;
        for (int i = 0; i < NE; i++)
          if (tgt < 0 && !m[i].v) tgt = i;
        if (tgt < 0) begin
          tgt  = m_rr;
          m_rr = (m_rr + 1) % NE;
        end
        m[tgt].v = 1; m[tgt].sd = int'(refill_sdid_i); m[tgt].base = base;
        m[tgt].sz = int'(refill_size_i); m[tgt].pm = int'(refill_perm_i);
      end
      e_done = (m_left == 1);
      if (ffire) begin
        for (int i = 0; i < NE; i++)
          if (!flush_sdid_valid_i || m[i].sd == int'(flush_sdid_i)) m[i].v = 0;
        m_left = NE;
      end else if (m_left > 0) begin
        m_left--;
      end
      e_busy = (m_left > 0);
    end
    @(posedge clk_i);
    #1;
    chk("resp_valid", resp_valid_o, e_rv);
    chk("busy", busy_o, e_busy);
    chk("flush_done", flush_done_o, e_done);
    if (e_rv || rst_i) begin
      chk("resp_hit", resp_hit_o, e_hit);
      chk("resp_perm", resp_perm_o, e_perm);
      chk("resp_allow", resp_allow_o, e_allow);
    end
  endtask

  task automatic do_reset();
    clr_in();
    rst_i = 1;
    tick();
    rst_i = 0;
  endtask

  task automatic rf(input logic [55:0] pa, input logic [5:0] sd, input logic [1:0] sz,
                    input logic [1:0] pm);
    clr_in();
    refill_valid_i = 1; refill_paddr_i = pa; refill_sdid_i = sd;
    refill_size_i = sz; refill_perm_i = pm;
    tick();
    clr_in();
  endtask

  task automatic lk(input string nm, input logic [55:0] pa, input logic [5:0] sd,
                    input logic [1:0] acc, input bit eh, input logic [1:0] ep, input bit ea);
    clr_in();
    lookup_valid_i = 1; lookup_paddr_i = pa; lookup_sdid_i = sd; lookup_access_i = acc;
    tick();
    clr_in();
    chk({nm, "_valid"}, resp_valid_o, 1);
    chk({nm, "_hit"}, resp_hit_o, eh);
    chk({nm, "_perm"}, resp_perm_o, ep);
    chk({nm, "_allow"}, resp_allow_o, ea);
  endtask

  function automatic logic [55:0] rand_pa();
    logic [55:0] a;
    a = '0;
    a[31:30] = 2'($urandom_range(0, 3));
    a[22:21] = 2'($urandom_range(0, 3));
    a[13:12] = 2'($urandom_range(0, 3));
    a[11:0]  = 12'($urandom);
    if ($urandom_range(0, 7) == 0) a[40] = 1'b1;
    return a;
  endfunction

  initial begin
    int busy_cnt, done_cnt;
    clr_in();
    rst_i = 1;
    model_reset();
    #1;
    tick();
    rst_i = 0;
    chk("reset_busy", busy_o, 0);
    chk("reset_done", flush_done_o, 0);
    chk("reset_resp_valid", resp_valid_o, 0);

    // lv lpa lsd lacc | rv rpa rsd rsz rpm | chk eh ep ea
    vecs.push_back(mkv(1, 56'h1000,      6'd3, 2'b01, 0, 56'h0,        6'd0, 2'b00, 2'b00, 1, 0, 2'b00, 0));
    vecs.push_back(mkv(0, 56'h0,         6'd0, 2'b00, 1, 56'h4000_0000, 6'd3, 2'b10, 2'b01, 0, 0, 2'b00, 0));
    vecs.push_back(mkv(1, 56'h7FFF_F123, 6'd3, 2'b10, 0, 56'h0,        6'd0, 2'b00, 2'b00, 1, 1, 2'b01, 0));
    vecs.push_back(mkv(1, 56'h7FFF_F123, 6'd3, 2'b11, 0, 56'h0,        6'd0, 2'b00, 2'b00, 1, 1, 2'b01, 1));
    vecs.push_back(mkv(1, 56'h7FFF_F123, 6'd4, 2'b01, 0, 56'h0,        6'd0, 2'b00, 2'b00, 1, 0, 2'b00, 0));
    vecs.push_back(mkv(1, 56'h5ABC,      6'd2, 2'b01, 1, 56'h5000,     6'd2, 2'b00, 2'b10, 1, 0, 2'b00, 0));
    vecs.push_back(mkv(1, 56'h5ABC,      6'd2, 2'b10, 0, 56'h0,        6'd0, 2'b00, 2'b00, 1, 1, 2'b10, 1));
    vecs.push_back(mkv(1, 56'h5ABC,      6'd2, 2'b11, 0, 56'h0,        6'd0, 2'b00, 2'b00, 1, 1, 2'b10, 0));
    vecs.push_back(mkv(1, 56'h5ABC,      6'd2, 2'b00, 0, 56'h0,        6'd0, 2'b00, 2'b00, 1, 1, 2'b10, 0));
    vecs.push_back(mkv(0, 56'h0,         6'd0, 2'b00, 1, 56'h6000,     6'd2, 2'b11, 2'b11, 0, 0, 2'b00, 0));
    vecs.push_back(mkv(1, 56'h6000,      6'd2, 2'b01, 0, 56'h0,        6'd0, 2'b00, 2'b00, 1, 0, 2'b00, 0));
    vecs.push_back(mkv(0, 56'h0,         6'd0, 2'b00, 1, 56'h60_0000,  6'd2, 2'b01, 2'b10, 0, 0, 2'b00, 0));
    vecs.push_back(mkv(1, 56'h7F_FFFF,   6'd2, 2'b10, 0, 56'h0,        6'd0, 2'b00, 2'b00, 1, 1, 2'b10, 1));
    vecs.push_back(mkv(1, 56'h80_0000,   6'd2, 2'b10, 0, 56'h0,        6'd0, 2'b00, 2'b00, 1, 0, 2'b00, 0));

    foreach (vecs[k]) begin
      clr_in();
      lookup_valid_i = vecs[k].lv; lookup_paddr_i = vecs[k].lpa;
      lookup_sdid_i = vecs[k].lsd; lookup_access_i = vecs[k].lacc;
      refill_valid_i = vecs[k].rv; refill_paddr_i = vecs[k].rpa;
      refill_sdid_i = vecs[k].rsd; refill_size_i = vecs[k].rsz; refill_perm_i = vecs[k].rpm;
      tick();
      clr_in();
      if (vecs[k].chk) begin
        chk($sformatf("vec%0d_valid", k), resp_valid_o, 1);
        chk($sformatf("vec%0d_hit", k), resp_hit_o, vecs[k].eh);
        chk($sformatf("vec%0d_perm", k), resp_perm_o, vecs[k].ep);
        chk($sformatf("vec%0d_allow", k), resp_allow_o, vecs[k].ea);
      end
    end

    // Round-robin eviction and overwrite-in-place.
    do_reset();
    for (int p = 'h10; p <= 'h13; p++) rf(56'(p) << 12, 6'd1, 2'b00, 2'b01);
    rf(56'h14000, 6'd1, 2'b00, 2'b01);
    lk("ev_p10", 56'h10000, 6'd1, 2'b01, 0, 2'b00, 0);
    lk("ev_p14", 56'h14000, 6'd1, 2'b01, 1, 2'b01, 1);
    rf(56'h15000, 6'd1, 2'b00, 2'b01);
    lk("ev_p11", 56'h11000, 6'd1, 2'b01, 0, 2'b00, 0);
    lk("ev_p12", 56'h12000, 6'd1, 2'b01, 1, 2'b01, 1);
    rf(56'h12000, 6'd1, 2'b00, 2'b11);
    lk("ow_p12", 56'h12000, 6'd1, 2'b10, 1, 2'b11, 1);
    rf(56'h16000, 6'd1, 2'b00, 2'b01);
    lk("rr_p13", 56'h13000, 6'd1, 2'b01, 1, 2'b01, 1);
    lk("rr_p12", 56'h12000, 6'd1, 2'b01, 0, 2'b00, 0);

    // Per-SDID flush colliding with a refill; a re-issued flush mid-sweep is ignored.
    do_reset();
    rf(56'h20000, 6'd1, 2'b00, 2'b11);
    rf(56'h30000, 6'd2, 2'b00, 2'b11);
    rf(56'h21000, 6'd1, 2'b00, 2'b11);
    rf(56'h31000, 6'd2, 2'b00, 2'b11);
    clr_in();
    flush_i = 1; flush_sdid_valid_i = 1; flush_sdid_i = 6'd1;
    refill_valid_i = 1; refill_paddr_i = 56'h40000; refill_sdid_i = 6'd2;
    tick();
    clr_in();
    busy_cnt = int'(busy_o);
    done_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      clr_in();
      lookup_valid_i = (c < 6); lookup_paddr_i = 56'h30000; lookup_sdid_i = 6'd2;
      lookup_access_i = 2'b01;
      if (c == 1) begin flush_i = 1; flush_sdid_valid_i = 0; end
      tick();
      busy_cnt += int'(busy_o);
      done_cnt += int'(flush_done_o);
    end
    clr_in();
    chk("flush_busy_cycles", busy_cnt, NE);
    chk("flush_done_pulses", done_cnt, 1);
    lk("fl_sd1", 56'h20000, 6'd1, 2'b01, 0, 2'b00, 0);
    lk("fl_sd2", 56'h31000, 6'd2, 2'b10, 1, 2'b11, 1);
    lk("fl_refill_dropped", 56'h40000, 6'd2, 2'b01, 0, 2'b00, 0);

    // Reset in the second sweep cycle.
    do_reset();
    rf(56'h50000, 6'd1, 2'b00, 2'b10);
    clr_in();
    flush_i = 1; flush_sdid_valid_i = 1; flush_sdid_i = 6'd5;
    tick();
    clr_in();
    tick();
    rst_i = 1;
    tick();
    rst_i = 0;
    chk("rst_mid_busy", busy_o, 0);
    chk("rst_mid_done", flush_done_o, 0);
    lk("rst_mid_lookup", 56'h50000, 6'd1, 2'b01, 0, 2'b00, 0);

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      clr_in();
      lookup_valid_i     = 1'($urandom_range(0, 1));
      lookup_paddr_i     = rand_pa();
      lookup_sdid_i      = 6'($urandom_range(0, 3));
      lookup_access_i    = 2'($urandom_range(0, 3));
      refill_valid_i     = ($urandom_range(0, 2) == 0);
      refill_paddr_i     = rand_pa();
      refill_sdid_i      = 6'($urandom_range(0, 3));
      refill_size_i      = 2'($urandom_range(0, 3));
      refill_perm_i      = 2'($urandom_range(0, 3));
      flush_i            = ($urandom_range(0, 39) == 0);
      flush_sdid_valid_i = 1'($urandom_range(0, 1));
      flush_sdid_i       = 6'($urandom_range(0, 3));
      tick();
    end
    clr_in();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
